// File: rtl/sd_arb_pkg.sv
// sd_arb_pkg: shared types and helpers for the SD block arbiter and its round-robin picker.
package sd_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_e;
  function automatic int CH_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sd_block_arbiter_rr_arbiter.sv
// rr_arbiter: picks the first pending requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  pend,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [IW-1:0] j;
  // Walk offsets from farthest to nearest so the nearest pending channel wins.
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (pend[j]) idx = j;
    end
    valid = |pend;
    grant = valid ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/sd_block_arbiter.sv
// sd_block_arbiter: serialises per-channel sector requests onto one host SD block port
// with round-robin grant, CPU-wait tracking, buffer routing and an ack timeout.
module sd_block_arbiter import sd_arb_pkg::*; #(
  parameter int NUM_CH = 3,
  parameter int LBA_W  = 32,
  parameter int TO_W   = 24,
  localparam int IW    = CH_IDX_W(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    abort,
  input  logic [NUM_CH-1:0]       ch_rd,
  input  logic [NUM_CH-1:0]       ch_wr,
  input  logic [NUM_CH*LBA_W-1:0] ch_lba,
  output logic [NUM_CH-1:0]       ch_wait,
  output logic [NUM_CH-1:0]       ch_err,
  input  logic [NUM_CH*8-1:0]     ch_buff_din,
  output logic [NUM_CH-1:0]       ch_buff_wr,
  output logic                    host_rd,
  output logic                    host_wr,
  output logic [LBA_W-1:0]        host_lba,
  output logic [IW-1:0]           host_ch,
  input  logic                    host_ack,
  input  logic                    host_buff_wr,
  output logic [7:0]              host_buff_din
);
  state_e state_q, state_d;
  logic [NUM_CH-1:0] pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic [NUM_CH-1:0] wait_q, wait_d, err_q, err_d, gnt_oh, cur;
  logic [IW-1:0] rr_q, rr_d, host_ch_q, host_ch_d, gnt_idx;
  logic [LBA_W-1:0] host_lba_q, host_lba_d;
  logic [TO_W-1:0] timer_q, timer_d, timer_inc;
  logic host_rd_q, host_rd_d, host_wr_q, host_wr_d, ack_q;
  logic gnt_valid, ack_rise, ack_fall, timeout;

  rr_arbiter #(.N(NUM_CH), .IW(IW)) u_rr (
    .pend(pend_rd_q | pend_wr_q), .ptr(rr_q), .grant(gnt_oh), .idx(gnt_idx), .valid(gnt_valid)
  );

  assign ack_rise  = host_ack & ~ack_q;
  assign ack_fall  = ~host_ack & ack_q;
  assign timer_inc = timer_q + TO_W'(1);
  assign timeout   = &timer_inc;
  assign cur       = NUM_CH'(1) << host_ch_q;

  always_comb begin
    state_d = state_q;
    pend_rd_d = pend_rd_q;
    pend_wr_d = pend_wr_q;
    wait_d = wait_q;
    err_d = '0;
    rr_d = rr_q;
    host_ch_d = host_ch_q;
    host_lba_d = host_lba_q;
    host_rd_d = host_rd_q;
    host_wr_d = host_wr_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: if (gnt_valid) begin
        host_ch_d = gnt_idx;
        host_lba_d = ch_lba[gnt_idx*LBA_W +: LBA_W];
        host_rd_d = |(gnt_oh & pend_rd_q);
        host_wr_d = ~|(gnt_oh & pend_rd_q);
        timer_d = '0;
        state_d = REQ;
      end
      REQ: if (ack_rise) begin
        host_rd_d = 1'b0;
        host_wr_d = 1'b0;
        pend_rd_d = host_rd_q ? pend_rd_q & ~cur : pend_rd_q;
        pend_wr_d = host_wr_q ? pend_wr_q & ~cur : pend_wr_q;
        state_d = XFER;
      end else if (timeout) begin
        host_rd_d = 1'b0;
        host_wr_d = 1'b0;
        pend_rd_d = pend_rd_q & ~cur;
        pend_wr_d = pend_wr_q & ~cur;
        wait_d = wait_q & ~cur;
        err_d = cur;
        state_d = IDLE;
      end else begin
        timer_d = timer_inc;
      end
      XFER: if (ack_fall) begin
        wait_d = wait_q & ~cur;
        rr_d = (host_ch_q == IW'(NUM_CH - 1)) ? '0 : host_ch_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // New pulses win over same-cycle clears; wait stays up while anything is left pending.
    pend_rd_d = pend_rd_d | ch_rd;
    pend_wr_d = pend_wr_d | ch_wr;
    wait_d = wait_d | pend_rd_d | pend_wr_d;
    if (abort) begin
      pend_rd_d = '0;
      pend_wr_d = '0;
      wait_d = '0;
      err_d = '0;
      host_rd_d = 1'b0;
      host_wr_d = 1'b0;
      timer_d = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_rd_q <= '0;
      pend_wr_q <= '0;
      wait_q <= '0;
      err_q <= '0;
      rr_q <= '0;
      host_ch_q <= '0;
      host_lba_q <= '0;
      host_rd_q <= 1'b0;
      host_wr_q <= 1'b0;
      timer_q <= '0;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_rd_q <= pend_rd_d;
      pend_wr_q <= pend_wr_d;
      wait_q <= wait_d;
      err_q <= err_d;
      rr_q <= rr_d;
      host_ch_q <= host_ch_d;
      host_lba_q <= host_lba_d;
      host_rd_q <= host_rd_d;
      host_wr_q <= host_wr_d;
      timer_q <= timer_d;
      ack_q <= host_ack;
    end
  end

  assign ch_wait = wait_q;
  assign ch_err = err_q;
  assign host_rd = host_rd_q;
  assign host_wr = host_wr_q;
  assign host_lba = host_lba_q;
  assign host_ch = host_ch_q;
  assign ch_buff_wr = (state_q == XFER && host_ack && host_buff_wr) ? cur : '0;
  assign host_buff_din = ch_buff_din[host_ch_q*8 +: 8];
endmodule

// File: tb/tb_sd_block_arbiter.sv
// tb_sd_block_arbiter: directed scenarios checked against a transaction-level model every cycle,
// plus hand-computed literal expectations.
module tb_sd_block_arbiter;
  localparam int TO_CYC = 15;
  logic clk = 1'b0, reset_n = 1'b0, abort = 1'b0;
  logic [2:0] ch_rd = '0, ch_wr = '0, ch_wait, ch_err, ch_buff_wr;
  logic [31:0] lba [3];
  logic [7:0] din [3];
  logic [95:0] ch_lba;
  logic [23:0] ch_buff_din;
  logic host_rd, host_wr, host_ack = 1'b0, host_buff_wr = 1'b0;
  logic [31:0] host_lba;
  logic [1:0] host_ch;
  logic [7:0] host_buff_din;
  int n_chk = 0, n_pass = 0;

  assign ch_lba = {lba[2], lba[1], lba[0]};
  assign ch_buff_din = {din[2], din[1], din[0]};

  sd_block_arbiter #(.NUM_CH(3), .LBA_W(32), .TO_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .abort(abort), .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_lba(ch_lba),
    .ch_wait(ch_wait), .ch_err(ch_err), .ch_buff_din(ch_buff_din), .ch_buff_wr(ch_buff_wr),
    .host_rd(host_rd), .host_wr(host_wr), .host_lba(host_lba), .host_ch(host_ch),
    .host_ack(host_ack), .host_buff_wr(host_buff_wr), .host_buff_din(host_buff_din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  // Transaction-level model: one outstanding transfer, pending bits per channel, rr pointer.
  logic [2:0] m_prd = '0, m_pwr = '0, m_wait = '0, m_err = '0;
  int m_rr = 0, m_ch = 0, m_age = 0, m_c = 0;
  bit m_act = 0, m_acked = 0, m_iswr = 0, m_prev = 0;
  logic [31:0] m_lba = '0;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_prd = '0; m_pwr = '0; m_wait = '0; m_err = '0;
      m_rr = 0; m_ch = 0; m_age = 0; m_act = 0; m_acked = 0; m_iswr = 0; m_prev = 0; m_lba = '0;
    end else begin
      m_err = '0;
      if (abort) begin
        m_prd = '0; m_pwr = '0; m_wait = '0; m_act = 0;
      end else begin
        if (!m_act) begin
          for (int off = 0; off < 3; off++) begin
            m_c = (m_rr + off) % 3;
            if (!m_act && (m_prd[m_c] || m_pwr[m_c])) begin
              m_act = 1; m_acked = 0; m_age = 0; m_ch = m_c; m_iswr = !m_prd[m_c]; m_lba = lba[m_c];
            end
          end
        end else if (!m_acked) begin
          if (host_ack && !m_prev) begin
            m_acked = 1;
            if (m_iswr) m_pwr[m_ch] = 1'b0; else m_prd[m_ch] = 1'b0;
          end else begin
            m_age = m_age + 1;
            if (m_age == TO_CYC) begin
              m_act = 0; m_prd[m_ch] = 1'b0; m_pwr[m_ch] = 1'b0; m_wait[m_ch] = 1'b0; m_err[m_ch] = 1'b1;
            end
          end
        end else if (!host_ack && m_prev) begin
          m_act = 0; m_wait[m_ch] = 1'b0; m_rr = (m_ch + 1) % 3;
        end
        m_prd = m_prd | ch_rd;
        m_pwr = m_pwr | ch_wr;
        m_wait = m_wait | ch_rd | ch_wr | m_prd | m_pwr;
      end
      m_prev = host_ack;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("host_rd", 64'(host_rd), 64'(m_act && !m_acked && !m_iswr));
    chk("host_wr", 64'(host_wr), 64'(m_act && !m_acked && m_iswr));
    chk("ch_wait", 64'(ch_wait), 64'(m_wait));
    chk("ch_err", 64'(ch_err), 64'(m_err));
    chk("ch_buff_wr", 64'(ch_buff_wr), (m_act && m_acked && host_ack && host_buff_wr) ? 64'(1) << m_ch : 64'(0));
    chk("host_buff_din", 64'(host_buff_din), 64'(din[m_ch]));
    if (m_act) begin
      chk("host_ch", 64'(host_ch), 64'(m_ch));
      chk("host_lba", 64'(host_lba), 64'(m_lba));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_grant();
    int n = 0;
    while (!(host_rd || host_wr) && n < 20) begin cyc(1); n++; end
    chk("grant_seen", 64'(host_rd || host_wr), 64'(1));
  endtask

  task automatic serve(input int ch, input bit wr);
    wait_grant();
    chk("serve_ch", 64'(host_ch), 64'(ch));
    chk("serve_wr", 64'(host_wr), 64'(wr));
    host_ack = 1'b1; cyc(3);
    host_ack = 1'b0; cyc(1);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 3; i++) begin lba[i] = 32'h1000 * (i + 1); din[i] = 8'(8'h10 * (i + 1)); end
    cyc(2);
    chk("rst_host_rd", 64'(host_rd), 64'(0));
    chk("rst_ch_wait", 64'(ch_wait), 64'(0));
    chk("rst_host_lba", 64'(host_lba), 64'(0));
    reset_n = 1'b1; cyc(1);

    // Single read on channel 1 with a long ack and toggling buffer strobe.
    lba[1] = 32'h100;
    ch_rd = 3'b010; cyc(1); ch_rd = '0;
    chk("t1_wait_set", 64'(ch_wait), 64'(3'b010));
    chk("t1_no_rd_yet", 64'(host_rd), 64'(0));
    cyc(1);
    chk("t1_host_rd", 64'(host_rd), 64'(1));
    chk("t1_host_ch", 64'(host_ch), 64'(1));
    chk("t1_host_lba", 64'(host_lba), 64'(32'h100));
    cyc(3);
    host_ack = 1'b1;
    for (int i = 0; i < 512; i++) begin
      host_buff_wr = i[0];
      din[1] = 8'(i);
      if (i == 9) begin
        #1 chk("t1_buff_wr", 64'(ch_buff_wr), 64'(3'b010));
        chk("t1_buff_din", 64'(host_buff_din), 64'(9));
        chk("t1_rd_dropped", 64'(host_rd), 64'(0));
      end
      cyc(1);
    end
    chk("t1_wait_before_fall", 64'(ch_wait), 64'(3'b010));
    host_ack = 1'b0; host_buff_wr = 1'b0; cyc(1);
    chk("t1_wait_after_fall", 64'(ch_wait), 64'(0));
    cyc(2);

    // Three simultaneous requests from a fresh rr pointer.
    reset_n = 1'b0; cyc(1); reset_n = 1'b1; cyc(1);
    ch_rd = 3'b011; ch_wr = 3'b100; cyc(1); ch_rd = '0; ch_wr = '0;
    serve(0, 1'b0);
    serve(1, 1'b0);
    serve(2, 1'b1);
    chk("t2_wait_clear", 64'(ch_wait), 64'(0));

    // Ack never arrives: request drops after 15 cycles with a one-cycle error pulse.
    ch_rd = 3'b001; cyc(1); ch_rd = '0;
    wait_grant();
    cnt = 0;
    while (host_rd && cnt < 40) begin cyc(1); cnt++; end
    chk("t3_rd_cycles", 64'(cnt), 64'(15));
    chk("t3_err_pulse", 64'(ch_err), 64'(3'b001));
    chk("t3_wait_clr", 64'(ch_wait), 64'(0));
    cyc(1);
    chk("t3_err_gone", 64'(ch_err), 64'(0));
    ch_rd = 3'b010; cyc(1); ch_rd = '0;
    serve(1, 1'b0);

    // Abort during a write transfer on channel 2.
    ch_wr = 3'b100; cyc(1); ch_wr = '0;
    wait_grant();
    chk("t4_ch", 64'(host_ch), 64'(2));
    host_ack = 1'b1; cyc(1);
    host_buff_wr = 1'b1;
    #1 chk("t4_buff_wr_on", 64'(ch_buff_wr), 64'(3'b100));
    abort = 1'b1; cyc(1); abort = 1'b0;
    chk("t4_wait", 64'(ch_wait), 64'(0));
    chk("t4_buff_wr_off", 64'(ch_buff_wr), 64'(0));
    chk("t4_no_err", 64'(ch_err), 64'(0));
    cyc(2);
    chk("t4_idle", 64'(host_rd || host_wr), 64'(0));
    host_ack = 1'b0; host_buff_wr = 1'b0; cyc(2);

    // Asynchronous reset in the middle of a request.
    lba[0] = 32'hABCD;
    ch_rd = 3'b001; cyc(1); ch_rd = '0;
    wait_grant();
    chk("t5_lba", 64'(host_lba), 64'(32'hABCD));
    cyc(2);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_rd", 64'(host_rd), 64'(0));
    chk("t5_wait", 64'(ch_wait), 64'(0));
    chk("t5_lba0", 64'(host_lba), 64'(0));
    chk("t5_ch0", 64'(host_ch), 64'(0));
    cyc(1); reset_n = 1'b1; cyc(1);

    // Read and write on one channel together: read first, wait held, then the write.
    ch_rd = 3'b001; ch_wr = 3'b001; cyc(1); ch_rd = '0; ch_wr = '0;
    serve(0, 1'b0);
    chk("t6_wait_held", 64'(ch_wait), 64'(3'b001));
    serve(0, 1'b1);
    chk("t6_wait_clr", 64'(ch_wait), 64'(0));
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sd_block_arbiter.md
Name: sd_block_arbiter

Overview:
- Parametrised multi-channel block-request controller.
- Collects sector read/write requests from NUM_CH clients (floppy track loaders, HDD controller, future slots) and holds a per-channel CPU-wait line while each request is in progress.
- Serialises the requests onto one shared host SD block port using round-robin arbitration.
- Routes the host buffer write strobe and read data to and from the granted channel only.
- Adds an ack timeout with an error flag, which the existing single-drive HDD handshake does not have.

Parameters:
- NUM_CH, 3, number of client channels (1..8).
- LBA_W, 32, sector address width.
- TO_W, 24, width of the ack-timeout counter; timeout fires at 2^TO_W-1 cycles.

Ports:
- clk  in  1  system clock (14.318 MHz pixel clock domain).
- reset_n  in  1  asynchronous active-low reset.
- abort  in  1  synchronous soft abort (dd_reset equivalent); clears all pending work.
- ch_rd  in  NUM_CH  per-channel read request pulse.
- ch_wr  in  NUM_CH  per-channel write request pulse.
- ch_lba  in  NUM_CH*LBA_W  per-channel sector address, sampled at grant.
- ch_wait  out  NUM_CH  per-channel busy/CPU-wait.
- ch_err  out  NUM_CH  one-cycle pulse when a channel's request times out.
- ch_buff_din  in  NUM_CH*8  per-channel sector data toward host (write path).
- ch_buff_wr  out  NUM_CH  host_buff_wr gated to the granted channel.
- host_rd  out  1  read request to host.
- host_wr  out  1  write request to host.
- host_lba  out  LBA_W  latched sector address.
- host_ch  out  $clog2(NUM_CH)  granted channel index.
- host_ack  in  1  host acknowledge, high for the whole transfer.
- host_buff_wr  in  1  host buffer write strobe.
- host_buff_din  out  8  ch_buff_din slice for the granted channel (combinational mux).

Behaviour:
- Reset (async, reset_n=0):
  - host_rd, host_wr, host_lba, host_ch = 0; ch_wait, ch_err = 0.
  - pend_rd, pend_wr = 0; rr pointer = 0; state = IDLE; timer = 0.
- Request capture, every cycle:
  - pend_rd[i] |= ch_rd[i]; pend_wr[i] |= ch_wr[i].
  - ch_wait[i] is set on the same edge the pulse is captured (registered, 1-cycle latency).
  - If both rd and wr are pending on one channel, read is served first; wr stays pending and the channel is re-arbitrated later.
- States:
  - IDLE:
    - If any pend_rd|pend_wr, grant the first pending channel at or after the rr pointer, wrapping modulo NUM_CH.
    - Latch host_ch and host_lba; assert host_rd or host_wr; clear timer; go to REQ.
  - REQ:
    - On the host_ack rising edge (old_ack=0, ack=1): drop host_rd and host_wr, clear the served pend bit, go to XFER.
    - Timer increments each cycle; at all-ones: drop the request, clear that channel's pend bits, pulse ch_err, clear ch_wait, go to IDLE.
  - XFER:
    - On the host_ack falling edge: clear ch_wait[grant] unless another pend bit remains for that channel.
    - Set rr = grant+1 (wrapping); go to IDLE.
- Buffer routing:
  - ch_buff_wr[i] = host_buff_wr & host_ack & (host_ch==i) & (state==XFER).
  - ch_buff_wr is 0 in all other states.
- Boundary cases:
  - New pulse on the granted channel during XFER: latched and served in a later grant.
  - Simultaneous requests: exactly one grant per IDLE visit.
  - Same-cycle pulse and clear: the pulse wins and the pend bit stays set.
  - host_ack already high on entry to REQ: no rising edge, so the timer runs.
- abort:
  - Clears pend bits, ch_wait, host_rd, host_wr and timer; state goes to IDLE.
  - rr is kept; no ch_err pulse.
  - Asserted during XFER: ch_buff_wr is forced to 0 from the next cycle.
- Width rules:
  - rr and host_ch wrap explicitly when NUM_CH is not a power of two.
  - host_lba is zero-extended slice-exact from ch_lba[grant*LBA_W +: LBA_W].

Decomposition:
- Package sd_arb_pkg: state enum (IDLE, REQ, XFER) and a CH_IDX_W function computing $clog2 with a minimum of 1.
- One sub-module, rr_arbiter: pending vector plus pointer in, one-hot grant and index out, purely combinational. It is reusable by the future IDE controller.

Test Plan:
- NUM_CH=3, ch_rd[1] pulse with lba 0x100; host raises ack 5 cycles later for 512 cycles, then drops it:
  - host_rd=1 and host_ch=1 one cycle after the pulse; host_lba=0x100.
  - ch_wait[1] stays high until one cycle after the ack fall.
  - ch_buff_wr[1] toggles with host_buff_wr; ch_buff_wr[0] and ch_buff_wr[2] stay 0.
- ch_rd[0], ch_rd[1] and ch_wr[2] pulsed in the same cycle, rr=0 -> grants in order 0, 1, 2; host_wr asserted only on the third grant.
- TO_W=4, request with no host_ack -> host_rd drops after 15 cycles; ch_err pulses for 1 cycle; ch_wait clears; a following request is granted normally.
- abort mid-XFER on channel 2 -> ch_wait=0 next cycle; ch_buff_wr[2] forced to 0; no ch_err; state IDLE.
- reset_n low asynchronously mid-REQ -> all outputs 0 immediately, without a clock edge.
- ch_rd[0] and ch_wr[0] pulsed in the same cycle -> read served first; ch_wait[0] stays high throughout; write granted on the next IDLE visit.
